// File: rtl/ame_num_approx.sv
// ame_num_approx: power-of-two approximation of a signed operand via chunked scan.
// Build option AME_NUM_APPROX_ROUND_EN selects round-to-nearest; default is floor.
module ame_num_approx #(
  parameter int COMP_DATA_BITS = 64,
  parameter int SCAN_BITS      = 8
) (
  input  logic                              clk_i,
  input  logic                              rst_n_i,
  input  logic                              comp_init_i,
  output logic                              comp_busy_o,
  output logic                              comp_done_o,
  input  logic [COMP_DATA_BITS-1:0]         num_data_i,
  output logic [COMP_DATA_BITS-1:0]         num_approx_o,
  output logic                              num_approx_sign_o,
  output logic [$clog2(COMP_DATA_BITS)-1:0] num_approx_shift_o
);

  localparam int W  = COMP_DATA_BITS;
  localparam int N  = COMP_DATA_BITS / SCAN_BITS;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = $clog2(COMP_DATA_BITS);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SCAN  = 2'd1;
  localparam logic [1:0] ROUND = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  mag;
  logic          sign;
  logic          found;
  logic [PW-1:0] pos;

  logic [PW-1:0]        base;
  logic [SCAN_BITS-1:0] chunk;
  logic [PW-1:0]        off;
  logic                 hit;
  logic [PW-1:0]        hit_pos;
  logic [PW-1:0]        rpos;
  logic [W-1:0]         approx_nxt;
  logic [PW-1:0]        shift_nxt;

  // Leading-one search inside the chunk selected by the counter
  always_comb begin
    base  = PW'(cnt) * PW'(SCAN_BITS);
    chunk = SCAN_BITS'(mag >> base);
    off   = '0;
    for (int i = 0; i < SCAN_BITS; i++) begin
      if (chunk[i]) off = PW'(i);
    end
    hit     = |chunk;
    hit_pos = base + off;
  end

  // Result bit position, optionally rounded to the nearer power of two
  always_comb begin
    rpos = pos;
`ifdef AME_NUM_APPROX_ROUND_EN
    if (pos != '0 && pos != PW'(W - 1) && mag[pos - 1'b1]) begin
      rpos = pos + 1'b1;
    end
`endif
    approx_nxt = found ? (W'(1) << rpos) : '0;
    shift_nxt  = found ? rpos : '0;
  end

  // Control FSM, operand capture and registered results
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state              <= IDLE;
      cnt                <= '0;
      mag                <= '0;
      sign               <= 1'b0;
      found              <= 1'b0;
      pos                <= '0;
      comp_busy_o        <= 1'b0;
      comp_done_o        <= 1'b0;
      num_approx_o       <= '0;
      num_approx_sign_o  <= 1'b0;
      num_approx_shift_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (comp_init_i) begin
            sign        <= num_data_i[W-1];
            mag         <= num_data_i[W-1] ? -num_data_i : num_data_i;
            found       <= 1'b0;
            pos         <= '0;
            cnt         <= CW'(N - 1);
            comp_busy_o <= 1'b1;
            state       <= SCAN;
          end
        end
        SCAN: begin
          if (!found && hit) begin
            pos   <= hit_pos;
            found <= 1'b1;
          end
          if (cnt == '0) begin
            state <= ROUND;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ROUND: begin
          num_approx_o       <= approx_nxt;
          num_approx_shift_o <= shift_nxt;
          num_approx_sign_o  <= sign;
          comp_done_o        <= 1'b1;
          state              <= DONE;
        end
        default: begin
          comp_done_o <= 1'b0;
          comp_busy_o <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ame_num_approx.sv
// tb_ame_num_approx: randomized and directed checks against a log2-based model.
// Build with AME_NUM_APPROX_ROUND_EN to check the rounding variant.
module tb_ame_num_approx;

  logic        clk;
  logic        rst_n;
  logic        init;
  logic        busy;
  logic        done;
  logic [63:0] num;
  logic [63:0] approx;
  logic        sgn;
  logic [5:0]  shift;

  int errors;
  int checks;

  logic [63:0] prev_a;
  logic [5:0]  prev_s;
  logic        prev_g;

  ame_num_approx dut (
    .clk_i              (clk),
    .rst_n_i            (rst_n),
    .comp_init_i        (init),
    .comp_busy_o        (busy),
    .comp_done_o        (done),
    .num_data_i         (num),
    .num_approx_o       (approx),
    .num_approx_sign_o  (sgn),
    .num_approx_shift_o (shift)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model(input logic [63:0] v,
                                output logic [63:0] a,
                                output logic [5:0] sh,
                                output logic sg);
    logic [63:0] m;
    int p;
    sg = v[63];
    m  = sg ? 64'(-$signed(v)) : v;
    if (m == 64'd0) begin
      a  = '0;
      sh = '0;
    end else begin
      p = $clog2(m + 64'd1) - 1;
`ifdef AME_NUM_APPROX_ROUND_EN
      if (p > 0 && p < 63 &&
          (m - (64'd1 << p)) >= (64'd1 << (p - 1)))
        p = p + 1;
`endif
      a  = 64'd1 << p;
      sh = 6'(p);
    end
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    init  = 1'b0;
    num   = '0;
    #2;
    checks++;
    if ({busy, done, sgn, shift, approx} !== '0) begin
      errors++;
      $display("FAIL reset_in got=%h exp=0",
               {busy, done, sgn, shift, approx});
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, sgn, shift, approx} !== '0) begin
      errors++;
      $display("FAIL reset_out got=%h exp=0",
               {busy, done, sgn, shift, approx});
    end
    prev_a = '0;
    prev_s = '0;
    prev_g = 1'b0;
  endtask

  // Called at a negedge; drives init now and walks ncyc cycles.
  task automatic run_op(input logic [63:0] v, input int ra,
                        input int rb, input int ncyc);
    logic [63:0] ea;
    logic [5:0]  es;
    logic        eg;
    logic [63:0] xa;
    logic [5:0]  xs;
    logic        xg;
    model(v, ea, es, eg);
    init = 1'b1;
    num  = v;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      xa = (c >= 10) ? ea : prev_a;
      xs = (c >= 10) ? es : prev_s;
      xg = (c >= 10) ? eg : prev_g;
      checks++;
      if (busy !== 1'(c <= 10)) begin
        errors++;
        $display("FAIL busy v=%h c=%0d got=%b exp=%b",
                 v, c, busy, (c <= 10));
      end
      checks++;
      if (done !== 1'(c == 10)) begin
        errors++;
        $display("FAIL done v=%h c=%0d got=%b exp=%b",
                 v, c, done, (c == 10));
      end
      checks++;
      if (approx !== xa) begin
        errors++;
        $display("FAIL approx v=%h c=%0d got=%h exp=%h",
                 v, c, approx, xa);
      end
      checks++;
      if (shift !== xs) begin
        errors++;
        $display("FAIL shift v=%h c=%0d got=%0d exp=%0d",
                 v, c, shift, xs);
      end
      checks++;
      if (sgn !== xg) begin
        errors++;
        $display("FAIL sign v=%h c=%0d got=%b exp=%b",
                 v, c, sgn, xg);
      end
      if (c == 10) begin
        prev_a = ea;
        prev_s = es;
        prev_g = eg;
      end
      if (c == ra || c == rb) begin
        init = 1'b1;
        num  = 64'd1024;
      end else begin
        init = 1'b0;
      end
    end
    init = 1'b0;
  endtask

  task automatic test_directed();
    run_op(64'd40, 0, 0, 11);
    run_op(-64'sd48, 0, 0, 11);
    run_op(64'd0, 0, 0, 11);
    run_op(64'h8000_0000_0000_0000, 0, 0, 11);
    run_op(64'h7fff_ffff_ffff_ffff, 0, 0, 11);
    run_op(64'd3, 0, 0, 11);
    run_op(64'd6, 0, 0, 11);
    run_op(64'd7, 0, 0, 11);
    run_op(-64'sd1, 0, 0, 11);
  endtask

  task automatic test_busy_protocol();
    run_op(64'd5, 3, 10, 14);
  endtask

  task automatic test_reset_mid_scan();
    init = 1'b1;
    num  = 64'd12345;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      init = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, sgn, shift, approx} !== '0) begin
      errors++;
      $display("FAIL rst_mid got=%h exp=0",
               {busy, done, sgn, shift, approx});
    end
    @(negedge clk);
    rst_n = 1'b1;
    prev_a = '0;
    prev_s = '0;
    prev_g = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      checks++;
      if ({busy, done, sgn, shift, approx} !== '0) begin
        errors++;
        $display("FAIL rst_idle c=%0d got=%h exp=0",
                 c, {busy, done, sgn, shift, approx});
      end
    end
    run_op(-64'sd300, 0, 0, 11);
  endtask

  task automatic test_random();
    logic [63:0] v;
    for (int k = 0; k < 40; k++) begin
      v = {$urandom, $urandom} >> $urandom_range(0, 63);
      if ($urandom_range(0, 1) == 1) v = -v;
      run_op(v, 0, 0, 11);
    end
  endtask

  task automatic test_back_to_back();
    run_op(64'd100, 0, 0, 11);
    run_op(-64'sd1000, 0, 0, 11);
    run_op(64'd1 << 40, 0, 0, 12);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_directed();
    test_busy_protocol();
    test_reset_mid_scan();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
